// File: rtl/hit_conditioner.sv
// hit_conditioner
//   Conditions three raw drum switches (hat, cymbal, tom) for the video
//   pattern generator: synchronizes and debounces each switch, emits a
//   one-cycle strobe per accepted hit, and holds a per-channel flash level
//   for a configurable number of video frames.
//
//   Optional feature: define HIT_COUNT_EN to add three saturating 8-bit hit
//   counters. Without it hit_count_o is tied to 0 and count_clr_i is ignored.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a new synchronized level must persist (1..2^20-1)
//   FLASH_FRAMES     frames the flash level stays high after a hit (1..63)
//
// Ports
//   clk          pixel clock, all flops on its rising edge
//   rst_n        asynchronous active-low reset
//   hit_raw_i    [2:0] raw switches: bit0 hat, bit1 cymbal, bit2 tom
//   vsync_i      active-low vertical sync, synchronous to clk
//   count_clr_i  synchronous clear of the hit counters
//   hit_pulse_o  [2:0] one-cycle strobe per accepted hit
//   hit_flash_o  [2:0] registered flash level per channel
//   hit_count_o  [23:0] {tom, cymbal, hat} 8-bit hit counters
module hit_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned FLASH_FRAMES    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  hit_raw_i,
    input  logic        vsync_i,
    input  logic        count_clr_i,
    output logic [2:0]  hit_pulse_o,
    output logic [2:0]  hit_flash_o,
    output logic [23:0] hit_count_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]    FLASH_LOAD = 6'(FLASH_FRAMES);

    typedef enum logic {
        IDLE,
        FLASH
    } flash_state_t;

    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [2:0]    pulse_q;
    logic [2:0]    flash_q;
    logic [CW-1:0] db_cnt    [3];
    flash_state_t  state     [3];
    logic [5:0]    frame_cnt [3];
    logic          vsync_q;
    logic          vsync_qq;
    logic          frame_tick;

    // Two-flop synchronizers for the asynchronous switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= hit_raw_i;
            sync2 <= sync1;
        end
    end

    // Debounce: the stable level only follows the synchronized input once it
    // has differed for DEBOUNCE_CYCLES consecutive cycles. The pulse is taken
    // from the registered stable level so its latency is fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable   <= '0;
            stable_d <= '0;
            pulse_q  <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
            stable_d <= stable;
            pulse_q  <= stable & ~stable_d;
        end
    end

    // Frame tick on a falling edge of the registered vsync. Both stages
    // reset low, so no tick can appear in the first cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
        end else begin
            vsync_q  <= vsync_i;
            vsync_qq <= vsync_q;
        end
    end

    assign frame_tick = vsync_qq & ~vsync_q;

    // Flash FSMs; a pulse takes priority over a coincident frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_q <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                state[i]     <= IDLE;
                frame_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                case (state[i])
                    IDLE: begin
                        if (pulse_q[i]) begin
                            state[i]     <= FLASH;
                            frame_cnt[i] <= FLASH_LOAD;
                            flash_q[i]   <= 1'b1;
                        end
                    end
                    FLASH: begin
                        if (pulse_q[i]) begin
                            frame_cnt[i] <= FLASH_LOAD;
                        end else if (frame_tick) begin
                            if (frame_cnt[i] == 6'd1) begin
                                state[i]     <= IDLE;
                                frame_cnt[i] <= '0;
                                flash_q[i]   <= 1'b0;
                            end else begin
                                frame_cnt[i] <= frame_cnt[i] - 6'd1;
                            end
                        end
                    end
                    default: begin
                        state[i]     <= IDLE;
                        frame_cnt[i] <= '0;
                        flash_q[i]   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hit_pulse_o = pulse_q;
    assign hit_flash_o = flash_q;

`ifdef HIT_COUNT_EN
    logic [7:0] hit_cnt [3];

    // Saturating counters; clear wins over a coincident pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                hit_cnt[i] <= '0;
            end
        end else if (count_clr_i) begin
            for (int unsigned i = 0; i < 3; i++) begin
                hit_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (pulse_q[i] && (hit_cnt[i] != 8'hFF)) begin
                    hit_cnt[i] <= hit_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign hit_count_o = {hit_cnt[2], hit_cnt[1], hit_cnt[0]};
`else
    logic unused_count_clr;

    assign unused_count_clr = count_clr_i;
    assign hit_count_o      = '0;
`endif

endmodule

// File: tb/tb_hit_conditioner.sv
module tb_hit_conditioner;

    localparam int DB = 8;
    localparam int FF = 3;
    localparam int P  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  hit_raw_i = '0;
    logic        vsync_i = 1'b1;
    logic        count_clr_i = 1'b0;
    logic [2:0]  hit_pulse_o;
    logic [2:0]  hit_flash_o;
    logic [23:0] hit_count_o;

    hit_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .FLASH_FRAMES(FF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hit_raw_i(hit_raw_i),
        .vsync_i(vsync_i),
        .count_clr_i(count_clr_i),
        .hit_pulse_o(hit_pulse_o),
        .hit_flash_o(hit_flash_o),
        .hit_count_o(hit_count_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct { int cyc; logic [2:0] mask; } pulse_ev_t;
    typedef struct { logic [2:0] flash; logic [23:0] count; } state_ev_t;
    pulse_ev_t pq[$];
    state_ev_t sq[$];

    // Free-running short video frame: vsync low 2 of every P cycles.
    int vc = 0;
    always @(negedge clk) begin
        vc++;
        vsync_i = !((vc % P) < 2);
    end

    // Reference model. Raw levels are seen two edges late (synchronizer);
    // a level is accepted after DB consecutive differing samples; the
    // strobe shows one edge after acceptance; flash counts remaining frames.
    int       run [3];
    bit       lvl [3];
    bit       h1 [3];
    bit       h2 [3];
    bit       v1, v2;
    bit [2:0] pv, pn;
    int       rem [3];
    int       cnt [3];

    always @(posedge clk) begin
        bit        tick;
        bit [2:0]  pnew;
        state_ev_t se;
        cyc++;
        if (!rst_n) begin
            for (int ch = 0; ch < 3; ch++) begin
                run[ch] = 0; lvl[ch] = 0; h1[ch] = 0; h2[ch] = 0;
                rem[ch] = 0; cnt[ch] = 0;
            end
            v1 = 0; v2 = 0; pv = '0; pn = '0;
            pq.delete();
        end else begin
            tick = v2 && !v1;
            for (int ch = 0; ch < 3; ch++) begin
                if (pv[ch]) rem[ch] = FF;
                else if (tick && rem[ch] > 0) rem[ch] = rem[ch] - 1;
`ifdef HIT_COUNT_EN
                if (count_clr_i) cnt[ch] = 0;
                else if (pv[ch] && cnt[ch] < 255) cnt[ch] = cnt[ch] + 1;
`endif
            end
            pnew = '0;
            for (int ch = 0; ch < 3; ch++) begin
                if (h2[ch] != lvl[ch]) run[ch] = run[ch] + 1;
                else run[ch] = 0;
                if (run[ch] == DB) begin
                    lvl[ch] = !lvl[ch];
                    run[ch] = 0;
                    if (lvl[ch]) pnew[ch] = 1'b1;
                end
            end
            pv = pn;
            pn = pnew;
            if (pnew != 0) pq.push_back('{cyc + 1, pnew});
            for (int ch = 0; ch < 3; ch++) begin
                h2[ch] = h1[ch];
                h1[ch] = hit_raw_i[ch];
            end
            v2 = v1;
            v1 = vsync_i;
        end
        for (int ch = 0; ch < 3; ch++) se.flash[ch] = (rem[ch] > 0);
        se.count = {cnt[2][7:0], cnt[1][7:0], cnt[0][7:0]};
        sq.push_back(se);
    end

    // Monitor: pops expectations whenever the DUT presents output.
    always @(posedge clk) begin
        pulse_ev_t pe;
        state_ev_t se;
        #1;
        if (hit_pulse_o !== 3'b000) begin
            tests++;
            if (pq.size() == 0) begin
                fails++;
                $display("FAIL pulse_unexpected cyc=%0d got=%b expected none", cyc, hit_pulse_o);
            end else begin
                pe = pq.pop_front();
                if (pe.cyc != cyc || pe.mask !== hit_pulse_o) begin
                    fails++;
                    $display("FAIL pulse cyc=%0d got=%b expected=%b at cyc %0d",
                             cyc, hit_pulse_o, pe.mask, pe.cyc);
                end
            end
        end
        while (pq.size() > 0 && pq[0].cyc <= cyc) begin
            pe = pq.pop_front();
            tests++;
            fails++;
            $display("FAIL pulse_missed cyc=%0d got=%b expected=%b", cyc, hit_pulse_o, pe.mask);
        end
        tests++;
        if (sq.size() == 0) begin
            fails++;
            $display("FAIL state_queue_empty cyc=%0d", cyc);
        end else begin
            se = sq.pop_front();
            if (hit_flash_o !== se.flash || hit_count_o !== se.count) begin
                fails++;
                $display("FAIL flash_count cyc=%0d got flash=%b count=%h expected flash=%b count=%h",
                         cyc, hit_flash_o, hit_count_o, se.flash, se.count);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (hit_pulse_o !== 3'b000 || hit_flash_o !== 3'b000 || hit_count_o !== 24'h0) begin
            fails++;
            $display("FAIL %s got pulse=%b flash=%b count=%h expected all 0",
                     name, hit_pulse_o, hit_flash_o, hit_count_o);
        end
    endtask

    initial begin
        cycles(3);
        check_zero("reset_state");
        rst_n = 1'b1;
        cycles(20);

        // Single hat hit held 40 cycles.
        hit_raw_i[0] = 1'b1;
        cycles(40);
        hit_raw_i[0] = 1'b0;
        cycles(80);

        // Tom bouncing 5 high / 5 low: never accepted.
        repeat (10) begin
            hit_raw_i[2] = 1'b1; cycles(5);
            hit_raw_i[2] = 1'b0; cycles(5);
        end
        cycles(30);

        // Cymbal retrigger swept across every frame phase.
        for (int off = 0; off < P; off++) begin
            hit_raw_i[1] = 1'b1; cycles(12);
            hit_raw_i[1] = 1'b0; cycles(12 + off);
            hit_raw_i[1] = 1'b1; cycles(12);
            hit_raw_i[1] = 1'b0; cycles(5 * P);
        end

        // Clear then all three channels on the same edge.
        count_clr_i = 1'b1; cycles(1); count_clr_i = 1'b0;
        hit_raw_i = 3'b111; cycles(20);
        hit_raw_i = 3'b000; cycles(80);

        // 300 hat hits to saturate.
        repeat (300) begin
            hit_raw_i[0] = 1'b1; cycles(11);
            hit_raw_i[0] = 1'b0; cycles(11);
        end
        cycles(20);

        // Clear sampled on the same edge the hat pulse is consumed.
        hit_raw_i[0] = 1'b1;
        cycles(DB + 3);
        count_clr_i = 1'b1; cycles(1); count_clr_i = 1'b0;
        cycles(8);
        hit_raw_i[0] = 1'b0;
        cycles(60);

        // Randomized bursts and occasional clears.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) hit_raw_i ^= 3'($urandom_range(1, 7));
            count_clr_i = ($urandom_range(0, 63) == 0);
            cycles(1);
        end
        hit_raw_i = '0; count_clr_i = 1'b0;
        cycles(80);

        // Reset during hat flash and cymbal debounce; hat held through it.
        hit_raw_i[0] = 1'b1;
        cycles(DB + 6);
        hit_raw_i[1] = 1'b1;
        cycles(4);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        cycles(3);
        rst_n = 1'b1;
        cycles(60);
        hit_raw_i = '0;
        cycles(60);

        tests++;
        if (pq.size() != 0) begin
            fails++;
            $display("FAIL pending_pulses got=%0d expected=0", pq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hit_conditioner.md
HIT_CONDITIONER -- requirements
Module: hit_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, consecutive clk cycles a synchronized input must hold a new level before it is accepted (10 ms at 25 MHz); legal range 1..2^20-1.
REQ-002 Parameter FLASH_FRAMES, default 6, video frames the flash output stays high after a hit; legal range 1..63.
REQ-003 Port clk  in  1  pixel clock, the only clock; every flop SHALL be on its rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port hit_raw_i  in  3  raw drum switches, active-high, asynchronous: bit 0 hat, bit 1 cymbal, bit 2 tom.
REQ-006 Port vsync_i  in  1  active-low VGA vertical sync, synchronous to clk.
REQ-007 Port count_clr_i  in  1  synchronous clear of the hit counters, active-high.
REQ-008 Port hit_pulse_o  out  3  one-cycle strobe per accepted hit, same bit order as hit_raw_i.
REQ-009 Port hit_flash_o  out  3  registered level to the pattern generator's hit inputs, held for FLASH_FRAMES frames.
REQ-010 Port hit_count_o  out  24  three 8-bit hit counters: [7:0] hat, [15:8] cymbal, [23:16] tom.

Function
REQ-011 Each hit_raw_i bit SHALL pass through its own 2-flop synchronizer before any other logic uses it.
REQ-012 Each channel SHALL have a stable-level flop and a debounce counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-013 Debounce counter: clears whenever the synchronized input equals the stable level; otherwise increments by 1.
REQ-014 When the counter reaches DEBOUNCE_CYCLES-1 with the input still differing, the stable level SHALL toggle and the counter SHALL clear.
REQ-015 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the stable level and all outputs unchanged.
REQ-016 hit_pulse_o[n] SHALL be high for exactly one cycle on each 0->1 transition of the stable level; a 1->0 transition produces no pulse.
REQ-017 A raw input that rises and then holds SHALL produce its pulse DEBOUNCE_CYCLES+3 clk edges after the first edge that samples it high, with no jitter.
REQ-018 Frame tick: a one-cycle internal strobe on every 1->0 transition of registered vsync_i; the first cycle after reset SHALL NOT produce a tick.
REQ-019 Each channel SHALL have a flash FSM with states IDLE and FLASH plus a 6-bit frame counter.
REQ-020 FSM IDLE: on a pulse, go to FLASH and load FLASH_FRAMES.
REQ-021 FSM FLASH: on each frame tick, decrement the frame counter; a tick at count 1 SHALL return the FSM to IDLE.
REQ-022 A pulse in FLASH SHALL reload FLASH_FRAMES (retrigger); when a pulse and a tick occur in the same cycle, the reload wins.
REQ-023 hit_flash_o[n] SHALL be 1 exactly when its FSM is in FLASH, so it rises one cycle after the pulse.
REQ-024 Channels SHALL be fully independent; simultaneous hits on all three channels SHALL each be processed with no loss.

Reset
REQ-025 While rst_n=0, all synchronizers, stable levels, debounce counters, frame counters, the vsync register and all outputs SHALL be 0, and all FSMs SHALL be in IDLE.
REQ-026 Asserting rst_n mid-debounce or mid-flash SHALL abort immediately with no pulse; after release, an input already high SHALL be debounced afresh and produce one pulse.

Configuration
REQ-027 Macro HIT_COUNT_EN defined: each channel keeps an 8-bit counter that increments on its hit pulse and saturates at 255.
REQ-028 With HIT_COUNT_EN, count_clr_i sets all three counters to 0 on the next edge; clear wins over a coincident pulse.
REQ-029 Macro HIT_COUNT_EN undefined: no counter flops exist, hit_count_o SHALL be constant 0, and count_clr_i SHALL be ignored.

Verification (DEBOUNCE_CYCLES=8, FLASH_FRAMES=3, short vsync period)
REQ-030 Raw hat high held 40 cycles -> single hit_pulse_o[0] exactly 11 edges after first sample; hit_flash_o[0] high for 3 frame ticks, then 0.
REQ-031 Tom toggling with 5-cycle high / 5-cycle low bursts for 100 cycles -> no pulse and hit_flash_o[2] stays 0.
REQ-032 Second cymbal hit during frame 2 of its flash -> counter reloads to 3; flash ends 3 ticks after the second pulse; reload wins if the pulse coincides with a tick.
REQ-033 All three inputs rise on the same edge -> three pulses in the same cycle; with HIT_COUNT_EN, hit_count_o = 0x010101.
REQ-034 With HIT_COUNT_EN: 300 hat hits -> [7:0] = 255; count_clr_i coincident with a pulse -> 0; without the macro -> always 0.
REQ-035 rst_n pulled low during FLASH and mid-debounce -> all outputs 0 asynchronously; held-high input after release -> exactly one pulse after 11 edges.
